// File: rtl/display_scheduler.sv
// Shares a 4-digit seven-segment display between the round timer, the player
// score and one-shot messages. Timer and score rotate on fixed dwell times,
// a message pre-empts the rotation, and the display blinks while paused or
// after game over. All outputs are registered, one clock after state/inputs.
module display_scheduler #(
    parameter int PRESCALE    = 100000,
    parameter int DWELL_TIMER = 3000,
    parameter int DWELL_SCORE = 1000,
    parameter int MSG_TICKS   = 500,
    parameter int BLINK_TICKS = 250,
    parameter bit LZ_SUPPRESS = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] timer_bcd,
    input  logic [15:0] score_bcd,
    input  logic        msg_req,
    input  logic [15:0] msg_bcd,
    input  logic        paused,
    input  logic        game_over,
    input  logic        start,
    output logic [3:0]  digit_1,
    output logic [3:0]  digit_2,
    output logic [3:0]  digit_3,
    output logic [3:0]  digit_4,
    output logic [1:0]  src
);

    localparam int DWELL_MAX = (DWELL_TIMER > DWELL_SCORE) ? DWELL_TIMER : DWELL_SCORE;
    localparam int PW = $clog2(PRESCALE + 1);
    localparam int DW = $clog2(DWELL_MAX + 1);
    localparam int HW = $clog2(MSG_TICKS + 1);
    localparam int BW = $clog2(BLINK_TICKS + 1);

    // Encoding doubles as the src output code.
    typedef enum logic [1:0] {
        ST_TIMER = 2'd0,
        ST_SCORE = 2'd1,
        ST_MSG   = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    state_t        ret_q, ret_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [15:0]   msg_q, msg_d;
    logic [15:0]   digits_q, digits_d;
    logic [1:0]    src_q, src_d;

    logic          tick_s;
    logic          blink_act_s;
    logic          blank_s;
    logic [DW-1:0] dwell_lim_s;
    state_t        rot_next_s;
    logic [15:0]   content_s;

    // Non-BCD nibbles are shown blank.
    function automatic logic [3:0] bcd_fix(input logic [3:0] n);
        return (n > 4'd9) ? 4'hF : n;
    endfunction

    // Sanitise all four nibbles of a BCD word.
    function automatic logic [15:0] bcd_word(input logic [15:0] w);
        return {bcd_fix(w[15:12]), bcd_fix(w[11:8]), bcd_fix(w[7:4]), bcd_fix(w[3:0])};
    endfunction

    // Score view: leading zeros of digit_1..digit_3 blanked, digit_4 always shown.
    function automatic logic [15:0] score_view(input logic [15:0] s);
        logic lz1, lz2, lz3;
        lz1 = LZ_SUPPRESS && (s[15:12] == 4'd0);
        lz2 = lz1 && (s[11:8] == 4'd0);
        lz3 = lz2 && (s[7:4] == 4'd0);
        return {lz1 ? 4'hF : bcd_fix(s[15:12]),
                lz2 ? 4'hF : bcd_fix(s[11:8]),
                lz3 ? 4'hF : bcd_fix(s[7:4]),
                bcd_fix(s[3:0])};
    endfunction

    // Next-state logic: prescaler, rotation/message FSM, blink and output view.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        dwell_d     = dwell_q;
        hold_d      = hold_q;
        msg_d       = msg_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;

        tick_s  = (presc_q == PW'(PRESCALE - 1));
        presc_d = tick_s ? '0 : (presc_q + PW'(1));

        dwell_lim_s = (state_q == ST_TIMER) ? DW'(DWELL_TIMER - 1) : DW'(DWELL_SCORE - 1);
        rot_next_s  = (state_q == ST_TIMER) ? ST_SCORE : ST_TIMER;

        if (game_over) begin
            // OVER beats everything except reset; a pending message is dropped.
            state_d = ST_OVER;
            dwell_d = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                ST_TIMER, ST_SCORE: begin
                    if (msg_req) begin
                        state_d = ST_MSG;
                        ret_d   = state_q;
                        msg_d   = msg_bcd;
                        dwell_d = '0;
                        hold_d  = '0;
                    end else if (tick_s && !paused) begin
                        if (dwell_q == dwell_lim_s) begin
                            state_d = rot_next_s;
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q + DW'(1);
                        end
                    end else begin
                        dwell_d = dwell_q;
                    end
                end
                ST_MSG: begin
                    // Hold keeps counting while paused; a new request restarts it.
                    if (msg_req) begin
                        msg_d  = msg_bcd;
                        hold_d = '0;
                    end else if (tick_s) begin
                        if (hold_q == HW'(MSG_TICKS - 1)) begin
                            state_d = ret_q;
                            hold_d  = '0;
                            dwell_d = '0;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end else begin
                        hold_d = hold_q;
                    end
                end
                ST_OVER: begin
                    if (start) begin
                        state_d = ST_TIMER;
                        dwell_d = '0;
                        hold_d  = '0;
                    end else begin
                        state_d = ST_OVER;
                    end
                end
                default: begin
                    state_d = ST_TIMER;
                    dwell_d = '0;
                    hold_d  = '0;
                end
            endcase
        end

        // Blink runs only while paused outside MSG, or in OVER; clears otherwise.
        blink_act_s = (paused && (state_q != ST_MSG)) || (state_q == ST_OVER);
        if (!blink_act_s) begin
            blink_cnt_d = '0;
            blink_ph_d  = 1'b0;
        end else if (tick_s) begin
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end else begin
            blink_cnt_d = blink_cnt_q;
        end
        blank_s = blink_act_s && blink_ph_q;

        case (state_q)
            ST_TIMER: content_s = bcd_word(timer_bcd);
            ST_SCORE: content_s = score_view(score_bcd);
            ST_MSG:   content_s = bcd_word(msg_q);
            ST_OVER:  content_s = score_view(score_bcd);
            default:  content_s = 16'hFFFF;
        endcase

        digits_d = blank_s ? 16'hFFFF : content_s;
        src_d    = state_q;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_TIMER;
            ret_q       <= ST_TIMER;
            presc_q     <= '0;
            dwell_q     <= '0;
            hold_q      <= '0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            msg_q       <= 16'h0000;
            digits_q    <= 16'hFFFF;
            src_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            presc_q     <= presc_d;
            dwell_q     <= dwell_d;
            hold_q      <= hold_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            msg_q       <= msg_d;
            digits_q    <= digits_d;
            src_q       <= src_d;
        end
    end

    assign digit_1 = digits_q[15:12];
    assign digit_2 = digits_q[11:8];
    assign digit_3 = digits_q[7:4];
    assign digit_4 = digits_q[3:0];
    assign src     = src_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with small timing parameters.
// Edge E_k is the k-th rising edge after reset release; checks are made on
// the falling edge following E_k. Ticks fall on edges E4, E8, E12, ...
module tb_display_scheduler;

    logic        clk;
    logic        rst;
    logic [15:0] timer_bcd;
    logic [15:0] score_bcd;
    logic        msg_req;
    logic [15:0] msg_bcd;
    logic        paused;
    logic        game_over;
    logic        start;
    logic [3:0]  digit_1, digit_2, digit_3, digit_4;
    logic [1:0]  src;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int base   = 0;

    display_scheduler #(
        .PRESCALE    (4),
        .DWELL_TIMER (3),
        .DWELL_SCORE (2),
        .MSG_TICKS   (2),
        .BLINK_TICKS (1),
        .LZ_SUPPRESS (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .timer_bcd (timer_bcd),
        .score_bcd (score_bcd),
        .msg_req   (msg_req),
        .msg_bcd   (msg_bcd),
        .paused    (paused),
        .game_over (game_over),
        .start     (start),
        .digit_1   (digit_1),
        .digit_2   (digit_2),
        .digit_3   (digit_3),
        .digit_4   (digit_4),
        .src       (src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge counter used to place stimulus on absolute edges.
    always @(posedge clk) edge_n <= edge_n + 1;

    // Advance to the falling edge after edge E_k.
    task automatic goto(input int k);
        while ((edge_n - base) < k) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] exp_dig, input logic [1:0] exp_src);
        logic [17:0] obs;
        logic [17:0] exp_v;
        obs   = {digit_1, digit_2, digit_3, digit_4, src};
        exp_v = {exp_dig, exp_src};
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed digits=%h src=%0d expected digits=%h src=%0d",
                   tag, obs[17:2], obs[1:0], exp_v[17:2], exp_v[1:0]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        timer_bcd = 16'h1234;
        score_bcd = 16'h0056;
        msg_req   = 1'b0;
        msg_bcd   = 16'h0000;
        paused    = 1'b0;
        game_over = 1'b0;
        start     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset", 16'hFFFF, 2'd0);
        base = edge_n;
        rst  = 1'b0;

        // 1: rotation, 12 clk timer then 8 clk score
        goto(1);  chk("rot_timer_first", 16'h1234, 2'd0);
        goto(12); chk("rot_timer_last",  16'h1234, 2'd0);
        goto(13); chk("rot_score_first", 16'hFF56, 2'd1);
        goto(20); chk("rot_score_last",  16'hFF56, 2'd1);
        goto(21); chk("rot_timer_again", 16'h1234, 2'd0);

        // 2: message pre-empts SCORE (SCORE entered at E32), sampled at E36
        goto(35); msg_req = 1'b1; msg_bcd = 16'h9999;
        goto(36); msg_req = 1'b0; msg_bcd = 16'h0000;
        chk("msg_latency", 16'hFF56, 2'd1);
        goto(37); chk("msg_first", 16'h9999, 2'd2);
        goto(44); chk("msg_last",  16'h9999, 2'd2);
        goto(45); chk("msg_ret_score", 16'hFF56, 2'd1);
        goto(52); chk("msg_ret_full_dwell", 16'hFF56, 2'd1);
        goto(53); chk("msg_then_timer", 16'h1234, 2'd0);

        // 3: pause during TIMER (one dwell tick already at E56)
        goto(57); paused = 1'b1;
        goto(60); chk("pause_visible", 16'h1234, 2'd0);
        goto(61); chk("pause_blank1",  16'hFFFF, 2'd0);
        goto(65); chk("pause_visible2_norot", 16'h1234, 2'd0);
        goto(69); chk("pause_blank2",  16'hFFFF, 2'd0);
        goto(70); paused = 1'b0;
        goto(72); chk("unpause_visible", 16'h1234, 2'd0);
        goto(76); chk("unpause_dwell_left", 16'h1234, 2'd0);
        goto(77); chk("unpause_rotate", 16'hFF56, 2'd1);

        // 4: game_over and msg_req together; OVER wins
        game_over = 1'b1; msg_req = 1'b1; msg_bcd = 16'h7777;
        goto(78); game_over = 1'b0; msg_req = 1'b0;
        goto(79); chk("over_enter", 16'hFF56, 2'd3);
        goto(81); chk("over_blank", 16'hFFFF, 2'd3);
        goto(82); msg_req = 1'b1;
        goto(83); msg_req = 1'b0;
        goto(85); chk("over_msg_ignored", 16'hFF56, 2'd3);
        goto(86); start = 1'b1;
        goto(87); start = 1'b0;
        chk("start_latency", 16'hFF56, 2'd3);
        goto(88); chk("start_timer", 16'h1234, 2'd0);

        // 5: bad BCD and leading-zero suppression
        timer_bcd = 16'h1A3F;
        goto(89); chk("bad_bcd", 16'h1F3F, 2'd0);
        goto(90); score_bcd = 16'h0000;
        goto(97); chk("score_zero", 16'hFFF0, 2'd1);
        score_bcd = 16'h0105;
        goto(98); chk("score_inner_zero", 16'hF105, 2'd1);

        // 6: reset in the middle of a message
        msg_req = 1'b1; msg_bcd = 16'h4321;
        goto(99); msg_req = 1'b0;
        goto(100); chk("msg_before_rst", 16'h4321, 2'd2);
        goto(101); rst = 1'b1; timer_bcd = 16'h1234;
        goto(102); chk("rst_mid_msg", 16'hFFFF, 2'd0);
        rst = 1'b0;
        goto(103); chk("rst_timer", 16'h1234, 2'd0);
        goto(114); chk("rst_fresh_dwell", 16'h1234, 2'd0);
        goto(115); chk("rst_then_score", 16'hF105, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
